// File: rtl/riscv_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_wb_arbiter_if
// Writeback bus bundle between the ALU / load-unit requesters, the arbiter and
// the register-file write port.
//   alu_wb_*          : ALU valid/addr/data request, ready grant
//   lsu_wb_*          : load-unit valid/addr/data request, ready grant
//   rf_wr_*           : registered register-file write port
//   contention_cnt_o  : saturating count of cycles with both requests valid
// Modports:
//   slave  : the arbiter (consumes requests, drives grants and the write port)
//   master : the surrounding pipeline (drives requests, observes the rest)
// -----------------------------------------------------------------------------
interface riscv_wb_arbiter_if #(
   parameter int CNT_W = 8
);
   logic             alu_wb_valid_i;
   logic [4:0]       alu_wb_addr_i;
   logic [31:0]      alu_wb_data_i;
   logic             alu_wb_ready_o;

   logic             lsu_wb_valid_i;
   logic [4:0]       lsu_wb_addr_i;
   logic [31:0]      lsu_wb_data_i;
   logic             lsu_wb_ready_o;

   logic             rf_wr_en_o;
   logic [4:0]       rf_wr_addr_o;
   logic [31:0]      rf_wr_data_o;
   logic [CNT_W-1:0] contention_cnt_o;

   modport slave (
      input  alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
      output alu_wb_ready_o,
      input  lsu_wb_valid_i, lsu_wb_addr_i, lsu_wb_data_i,
      output lsu_wb_ready_o,
      output rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
      output contention_cnt_o
   );

   modport master (
      output alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
      input  alu_wb_ready_o,
      output lsu_wb_valid_i, lsu_wb_addr_i, lsu_wb_data_i,
      input  lsu_wb_ready_o,
      input  rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
      input  contention_cnt_o
   );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_wb_arbiter
// Shares the single register-file write port between the ALU and the load
// unit. Grants are combinational from the valids and the last_grant flop
// (round-robin on contention); the accepted write is registered and presented
// to the register file one cycle after acceptance. Writes to x0 are accepted
// but never enabled. A saturating counter records contended cycles.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-low reset
//   wb     : riscv_wb_arbiter_if.slave (requests, grants, write port, counter)
// -----------------------------------------------------------------------------
module riscv_wb_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   riscv_wb_arbiter_if.slave        wb
);

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   grant_e           last_grant_q;
   logic             rf_wr_en_q;
   logic [4:0]       rf_wr_addr_q;
   logic [31:0]      rf_wr_data_q;
   logic [CNT_W-1:0] cnt_q;

   logic             alu_grant;
   logic             lsu_grant;
   logic             both_valid;

   // Grants depend only on the valids, last_grant and reset -- never on
   // addr/data -- so the requesters see no long combinational loop back.
   // Holding reset in the term keeps both grants low while in reset.
   assign both_valid = wb.alu_wb_valid_i & wb.lsu_wb_valid_i;
   assign alu_grant  = reset & wb.alu_wb_valid_i &
                       (~wb.lsu_wb_valid_i | (last_grant_q == GRANT_LSU));
   assign lsu_grant  = reset & wb.lsu_wb_valid_i &
                       (~wb.alu_wb_valid_i | (last_grant_q == GRANT_ALU));

   // NOTE: all state below is written with non-blocking assignments so every
   // flop samples pre-edge values; blocking here would create order-dependent
   // simulation that need not match the synthesized netlist.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= GRANT_LSU;   // first contested cycle then goes to ALU
         rf_wr_en_q   <= 1'b0;
         rf_wr_addr_q <= '0;
         rf_wr_data_q <= '0;
         cnt_q        <= '0;
      end else begin
         if (alu_grant) begin
            last_grant_q <= GRANT_ALU;
            rf_wr_addr_q <= wb.alu_wb_addr_i;
            rf_wr_data_q <= wb.alu_wb_data_i;
            rf_wr_en_q   <= (wb.alu_wb_addr_i != 5'd0);
         end else if (lsu_grant) begin
            last_grant_q <= GRANT_LSU;
            rf_wr_addr_q <= wb.lsu_wb_addr_i;
            rf_wr_data_q <= wb.lsu_wb_data_i;
            rf_wr_en_q   <= (wb.lsu_wb_addr_i != 5'd0);
         end else begin
            // Idle cycle: drop the enable, keep addr/data as last presented.
            rf_wr_en_q   <= 1'b0;
         end

         if (both_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign wb.alu_wb_ready_o   = alu_grant;
   assign wb.lsu_wb_ready_o   = lsu_grant;
   assign wb.rf_wr_en_o       = rf_wr_en_q;
   assign wb.rf_wr_addr_o     = rf_wr_addr_q;
   assign wb.rf_wr_data_o     = rf_wr_data_q;
   assign wb.contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_wb_arbiter
// Directed bench for riscv_wb_arbiter: one instance with the default counter
// width and one with CNT_W=2 for saturation. Inputs change and outputs are
// sampled just after the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_riscv_wb_arbiter;

   logic clk;
   logic reset;

   int n_cmp;
   int n_err;

   riscv_wb_arbiter_if #(.CNT_W(8)) wb  ();
   riscv_wb_arbiter_if #(.CNT_W(2)) wb2 ();

   riscv_wb_arbiter #(.CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb.slave)
   );

   riscv_wb_arbiter #(.CNT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .wb    (wb2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive_alu(input logic v, input logic [4:0] a,
                            input logic [31:0] d);
      wb.alu_wb_valid_i = v;
      wb.alu_wb_addr_i  = a;
      wb.alu_wb_data_i  = d;
   endtask

   task automatic drive_lsu(input logic v, input logic [4:0] a,
                            input logic [31:0] d);
      wb.lsu_wb_valid_i = v;
      wb.lsu_wb_addr_i  = a;
      wb.lsu_wb_data_i  = d;
   endtask

   // Advance to the next falling edge (inputs are then driven, then sample #1).
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   // Round-robin table: both ports stay valid; the granted port gets new data.
   logic [4:0]  rr_addr [6];
   logic [31:0] rr_data [6];
   logic [31:0] sat_exp [5];

   initial begin
      logic [31:0] alu_d;
      logic [31:0] lsu_d;

      n_cmp = 0;
      n_err = 0;
      rr_addr = '{5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4};
      rr_data = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
      sat_exp = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

      // ---- reset state, with both valids high to show grants are masked ----
      reset = 1'b0;
      drive_alu(1'b1, 5'd9, 32'h99);
      drive_lsu(1'b1, 5'd9, 32'h99);
      wb2.alu_wb_valid_i = 1'b0; wb2.alu_wb_addr_i = '0; wb2.alu_wb_data_i = '0;
      wb2.lsu_wb_valid_i = 1'b0; wb2.lsu_wb_addr_i = '0; wb2.lsu_wb_data_i = '0;
      repeat (2) cyc();
      #1;
      check("rst_alu_rdy", 32'(wb.alu_wb_ready_o), 32'd0);
      check("rst_lsu_rdy", 32'(wb.lsu_wb_ready_o), 32'd0);
      check("rst_en",      32'(wb.rf_wr_en_o), 32'd0);
      check("rst_addr",    32'(wb.rf_wr_addr_o), 32'd0);
      check("rst_data",    wb.rf_wr_data_o, 32'd0);
      check("rst_cnt",     32'(wb.contention_cnt_o), 32'd0);

      cyc();
      reset = 1'b1;
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu(1'b0, 5'd0, 32'h0);

      // ---- ALU only: addr 5, 0xDEADBEEF ----
      cyc();
      drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      check("alu_only_rdy",     32'(wb.alu_wb_ready_o), 32'd1);
      check("alu_only_lsu_rdy", 32'(wb.lsu_wb_ready_o), 32'd0);

      // ---- back-to-back LSU write to x0 ----
      cyc();
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu(1'b1, 5'd0, 32'hFFFFFFFF);
      #1;
      check("alu_only_en",   32'(wb.rf_wr_en_o), 32'd1);
      check("alu_only_addr", 32'(wb.rf_wr_addr_o), 32'd5);
      check("alu_only_data", wb.rf_wr_data_o, 32'hDEADBEEF);
      check("alu_only_cnt",  32'(wb.contention_cnt_o), 32'd0);
      check("x0_lsu_rdy",    32'(wb.lsu_wb_ready_o), 32'd1);
      check("x0_alu_rdy",    32'(wb.alu_wb_ready_o), 32'd0);

      // ---- contested after an LSU grant: ALU must win ----
      cyc();
      drive_alu(1'b1, 5'd10, 32'h1);
      drive_lsu(1'b1, 5'd11, 32'h2);
      #1;
      check("x0_en",        32'(wb.rf_wr_en_o), 32'd0);
      check("post_x0_alu",  32'(wb.alu_wb_ready_o), 32'd1);
      check("post_x0_lsu",  32'(wb.lsu_wb_ready_o), 32'd0);

      cyc();
      drive_alu(1'b0, 5'd0, 32'h0);
      #1;
      check("post_x0_lsu2", 32'(wb.lsu_wb_ready_o), 32'd1);
      check("post_x0_wa",   32'(wb.rf_wr_addr_o), 32'd10);

      cyc();
      drive_lsu(1'b0, 5'd0, 32'h0);
      #1;
      check("post_x0_en2",  32'(wb.rf_wr_en_o), 32'd1);
      check("post_x0_wb",   32'(wb.rf_wr_addr_o), 32'd11);
      check("post_x0_cnt",  32'(wb.contention_cnt_o), 32'd1);

      cyc();
      #1;
      check("idle_en",   32'(wb.rf_wr_en_o), 32'd0);
      check("idle_addr", 32'(wb.rf_wr_addr_o), 32'd11);
      check("idle_data", wb.rf_wr_data_o, 32'h2);

      // ---- contention after reset: ALU 1/0x11 then LSU 2/0x22 ----
      reset_pulse();
      cyc();
      drive_alu(1'b1, 5'd1, 32'h11);
      drive_lsu(1'b1, 5'd2, 32'h22);
      #1;
      check("cont_alu_rdy", 32'(wb.alu_wb_ready_o), 32'd1);
      check("cont_lsu_rdy", 32'(wb.lsu_wb_ready_o), 32'd0);

      cyc();
      drive_alu(1'b0, 5'd0, 32'h0);
      #1;
      check("cont_lsu_rdy2", 32'(wb.lsu_wb_ready_o), 32'd1);
      check("cont_w1_en",    32'(wb.rf_wr_en_o), 32'd1);
      check("cont_w1_addr",  32'(wb.rf_wr_addr_o), 32'd1);
      check("cont_w1_data",  wb.rf_wr_data_o, 32'h11);

      cyc();
      drive_lsu(1'b0, 5'd0, 32'h0);
      #1;
      check("cont_w2_en",   32'(wb.rf_wr_en_o), 32'd1);
      check("cont_w2_addr", 32'(wb.rf_wr_addr_o), 32'd2);
      check("cont_w2_data", wb.rf_wr_data_o, 32'h22);
      check("cont_cnt",     32'(wb.contention_cnt_o), 32'd1);

      // ---- round-robin: six contested cycles, fresh data after each grant ----
      reset_pulse();
      alu_d = 32'hA0;
      lsu_d = 32'hB0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         drive_alu(1'b1, 5'd3, alu_d);
         drive_lsu(1'b1, 5'd4, lsu_d);
         #1;
         check($sformatf("rr%0d_alu_rdy", k), 32'(wb.alu_wb_ready_o),
               (k % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr%0d_lsu_rdy", k), 32'(wb.lsu_wb_ready_o),
               (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k > 0) begin
            check($sformatf("rr%0d_en", k),   32'(wb.rf_wr_en_o), 32'd1);
            check($sformatf("rr%0d_addr", k), 32'(wb.rf_wr_addr_o),
                  32'(rr_addr[k-1]));
            check($sformatf("rr%0d_data", k), wb.rf_wr_data_o, rr_data[k-1]);
         end
         if (k % 2 == 0) alu_d = alu_d + 32'd1;
         else            lsu_d = lsu_d + 32'd1;
      end
      cyc();
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu(1'b0, 5'd0, 32'h0);
      #1;
      check("rr5_en",   32'(wb.rf_wr_en_o), 32'd1);
      check("rr5_addr", 32'(wb.rf_wr_addr_o), 32'(rr_addr[5]));
      check("rr5_data", wb.rf_wr_data_o, rr_data[5]);
      check("rr_cnt",   32'(wb.contention_cnt_o), 32'd6);

      // ---- async reset right after an ALU transfer to x7 ----
      cyc();
      drive_alu(1'b1, 5'd7, 32'h77);
      #1;
      check("rst_mid_alu_rdy", 32'(wb.alu_wb_ready_o), 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      drive_alu(1'b1, 5'd7, 32'h77);
      drive_lsu(1'b1, 5'd8, 32'h88);
      #1;
      check("rst_mid_en",   32'(wb.rf_wr_en_o), 32'd0);
      check("rst_mid_addr", 32'(wb.rf_wr_addr_o), 32'd0);
      check("rst_mid_alu",  32'(wb.alu_wb_ready_o), 32'd0);
      check("rst_mid_lsu",  32'(wb.lsu_wb_ready_o), 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_en",  32'(wb.rf_wr_en_o), 32'd0);
      check("rst_hold_alu", 32'(wb.alu_wb_ready_o), 32'd0);
      check("rst_hold_lsu", 32'(wb.lsu_wb_ready_o), 32'd0);

      cyc();
      reset = 1'b1;
      drive_alu(1'b1, 5'd12, 32'hC);
      drive_lsu(1'b1, 5'd13, 32'hD);
      #1;
      check("post_rst_alu", 32'(wb.alu_wb_ready_o), 32'd1);
      check("post_rst_lsu", 32'(wb.lsu_wb_ready_o), 32'd0);
      cyc();
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu(1'b0, 5'd0, 32'h0);

      // ---- saturation on the CNT_W=2 instance ----
      cyc();
      #1;
      check("sat_start", 32'(wb2.contention_cnt_o), 32'd0);
      wb2.alu_wb_valid_i = 1'b1;
      wb2.lsu_wb_valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         #1;
         check($sformatf("sat%0d_cnt", k), 32'(wb2.contention_cnt_o),
               sat_exp[k]);
      end
      wb2.alu_wb_valid_i = 1'b0;
      wb2.lsu_wb_valid_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating contention counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-004 alu_wb_valid_i  input  1  ALU writeback request.
REQ-005 alu_wb_addr_i  input  5  ALU destination register.
REQ-006 alu_wb_data_i  input  32  ALU writeback data.
REQ-007 alu_wb_ready_o  output  1  ALU request granted this cycle.
REQ-008 lsu_wb_valid_i  input  1  load-unit writeback request.
REQ-009 lsu_wb_addr_i  input  5  load-unit destination register.
REQ-010 lsu_wb_data_i  input  32  load-unit writeback data.
REQ-011 lsu_wb_ready_o  output  1  load-unit request granted this cycle.
REQ-012 rf_wr_en_o  output  1  register-file write enable.
REQ-013 rf_wr_addr_o  output  5  register-file write address.
REQ-014 rf_wr_data_o  output  32  register-file write data.
REQ-015 contention_cnt_o  output  CNT_W  count of cycles with both requests valid.

Function
REQ-016 The block SHALL share the single register-file write port between the ALU and load-unit requesters.
REQ-017 A transfer SHALL occur on a requester when valid and ready are both 1 at a rising edge.
REQ-018 Requesters SHALL hold valid, addr and data stable until ready; the block is not required to tolerate violations.
REQ-019 Ready outputs SHALL be combinational from the valid inputs and the last_grant flop; no combinational path from data or addr to ready.
REQ-020 At most one ready SHALL be 1 in any cycle, and ready SHALL be 0 on a port whose valid is 0.
REQ-021 Only one valid: that port SHALL be granted in the same cycle.
REQ-022 Both valid: the port not recorded in last_grant SHALL be granted (round-robin).
REQ-023 last_grant SHALL update to the granted port on every transfer; no transfer leaves it unchanged.
REQ-024 On a transfer, rf_wr_addr_o and rf_wr_data_o SHALL register the granted port's addr and data at that edge, and rf_wr_en_o SHALL register 1, so the write is presented exactly one cycle after acceptance.
REQ-025 A transfer with addr 0 SHALL be accepted (ready=1), and SHALL register rf_wr_en_o=0, so x0 is never written.
REQ-026 A cycle with no transfer SHALL register rf_wr_en_o=0; rf_wr_addr_o and rf_wr_data_o SHALL hold their previous values.
REQ-027 Sustained throughput SHALL be one write per cycle; the output stage never back-pressures.
REQ-028 contention_cnt_o SHALL increment by 1 on each edge where both valids are 1, saturating at 2^CNT_W-1 without wrap.
REQ-029 The block SHALL NOT reorder or merge requests; consecutive writes to the same address are presented in grant order.

Reset
REQ-030 While reset=0, the block SHALL drive rf_wr_en_o=0, rf_wr_addr_o=0, rf_wr_data_o=0 and contention_cnt_o=0, and last_grant SHALL be LSU.
REQ-031 While reset=0, alu_wb_ready_o and lsu_wb_ready_o SHALL be 0 regardless of the valid inputs.
REQ-032 Reset asserted mid-operation SHALL discard any registered, not-yet-presented write; no write SHALL reach the register file after reset assertion.
REQ-033 Following reset deassertion, the first contested cycle SHALL grant the ALU.

Verification
REQ-034 ALU-only scenario: ALU valid, addr 5, data 0xDEADBEEF for one cycle -> alu_wb_ready_o=1 that cycle; the next cycle has rf_wr_en_o=1, addr 5, data 0xDEADBEEF; contention_cnt_o=0.
REQ-035 Contention scenario: both valid and held after reset (ALU addr 1/0x11, LSU addr 2/0x22) -> ALU is granted first, then LSU; writes appear on consecutive cycles; contention_cnt_o=1.
REQ-036 Round-robin scenario: both valid continuously for 6 cycles with fresh data after each grant -> grants alternate ALU,LSU,ALU,LSU,ALU,LSU; contention_cnt_o=6; six consecutive rf_wr_en_o pulses.
REQ-037 x0 scenario: LSU valid, addr 0, data 0xFFFFFFFF -> lsu_wb_ready_o=1; the next cycle has rf_wr_en_o=0.
REQ-038 Saturation scenario: CNT_W=2 with both valid for 5 cycles -> contention_cnt_o reaches 3 and holds at 3.
REQ-039 Reset scenario: reset=0 asserted asynchronously the cycle after an ALU transfer (addr 7) -> rf_wr_en_o=0 immediately, no write is presented, and both ready outputs are 0 while reset=0.
